// File: rtl/hoplite_sw_if.sv
// Packet-level signal bundle for one Hoplite switch node: the West/North through-traffic,
// the PE injection port, the registered East/South outputs and the statistics counters.
interface hoplite_sw_if #(
    parameter int P_W   = 16,
    parameter int CNT_W = 16
);
    logic [P_W-1:0]   w_pkt;
    logic             w_vld;
    logic [P_W-1:0]   n_pkt;
    logic             n_vld;
    logic [P_W-1:0]   pe_in_pkt;
    logic             pe_in_vld;
    logic             sw_rdy;
    logic [P_W-1:0]   e_pkt;
    logic             e_vld;
    logic [P_W-1:0]   s_pkt;
    logic             s_vld;
    logic             pe_vld;
    logic [CNT_W-1:0] defl_cnt;
    logic [CNT_W-1:0] inj_cnt;

    // The master side feeds traffic into the switch and observes its outputs.
    modport master (
        output w_pkt, w_vld, n_pkt, n_vld, pe_in_pkt, pe_in_vld,
        input  sw_rdy, e_pkt, e_vld, s_pkt, s_vld, pe_vld, defl_cnt, inj_cnt
    );

    modport slave (
        input  w_pkt, w_vld, n_pkt, n_vld, pe_in_pkt, pe_in_vld,
        output sw_rdy, e_pkt, e_vld, s_pkt, s_vld, pe_vld, defl_cnt, inj_cnt
    );
endinterface

// File: rtl/hoplite_sw.sv
// Hoplite bufferless deflection switch: merges North, West and PE injection traffic onto
// registered East/South outputs with fixed N > W > PE priority and dimension-ordered routing.
module hoplite_sw #(
    parameter int P_W   = 16,
    parameter int X_AW  = 2,
    parameter int Y_AW  = 2,
    parameter int X_POS = 0,
    parameter int Y_POS = 0,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    hoplite_sw_if.slave bus
);

    localparam int              A_W        = X_AW + Y_AW;
    localparam logic [X_AW-1:0] X_ADDR     = X_AW'(X_POS);
    localparam logic [Y_AW-1:0] Y_ADDR     = Y_AW'(Y_POS);
    localparam logic [A_W-1:0]  LOCAL_ADDR = {Y_ADDR, X_ADDR};

    logic             w_wants_s;
    logic             pe_wants_s;
    logic             w_to_s;
    logic             w_to_e;
    logic             w_defl;
    logic             s_claimed;
    logic             e_claimed;
    logic             pe_rdy;
    logic             inject;
    logic             pe_to_s;
    logic             pe_to_e;

    logic             e_vld_q;
    logic [P_W-1:0]   e_pkt_q;
    logic             s_raw_vld_q;
    logic [P_W-1:0]   s_pkt_q;
    logic [CNT_W-1:0] defl_cnt_q;
    logic [CNT_W-1:0] inj_cnt_q;
    logic             local_hit;

    // Dimension-ordered routing: turn South once the X coordinate matches, else keep going East.
    // North always owns South, so a West packet that wants South while North is valid is bounced East.
    always_comb begin
        w_wants_s  = (bus.w_pkt[X_AW-1:0] == X_ADDR);
        pe_wants_s = (bus.pe_in_pkt[X_AW-1:0] == X_ADDR);

        w_to_s     = bus.w_vld & w_wants_s & ~bus.n_vld;
        w_to_e     = bus.w_vld & ~w_to_s;
        w_defl     = bus.w_vld & w_wants_s & bus.n_vld;

        s_claimed  = bus.n_vld | w_to_s;
        e_claimed  = w_to_e;

        pe_rdy     = pe_wants_s ? ~s_claimed : ~e_claimed;
        inject     = bus.pe_in_vld & pe_rdy;
        pe_to_s    = inject & pe_wants_s;
        pe_to_e    = inject & ~pe_wants_s;
    end

    // East output register; the packet field only loads when a winner exists.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_vld_q <= 1'b0;
            e_pkt_q <= '0;
        end else begin
            e_vld_q <= w_to_e | pe_to_e;
            if (w_to_e) begin
                e_pkt_q <= bus.w_pkt;
            end else if (pe_to_e) begin
                e_pkt_q <= bus.pe_in_pkt;
            end
        end
    end

    // South output register, shared between the downstream link and local delivery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_raw_vld_q <= 1'b0;
            s_pkt_q     <= '0;
        end else begin
            s_raw_vld_q <= bus.n_vld | w_to_s | pe_to_s;
            if (bus.n_vld) begin
                s_pkt_q <= bus.n_pkt;
            end else if (w_to_s) begin
                s_pkt_q <= bus.w_pkt;
            end else if (pe_to_s) begin
                s_pkt_q <= bus.pe_in_pkt;
            end
        end
    end

    // Statistics counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            defl_cnt_q <= '0;
            inj_cnt_q  <= '0;
        end else begin
            if (w_defl && !(&defl_cnt_q)) begin
                defl_cnt_q <= defl_cnt_q + CNT_W'(1);
            end
            if (inject && !(&inj_cnt_q)) begin
                inj_cnt_q <= inj_cnt_q + CNT_W'(1);
            end
        end
    end

    assign local_hit    = (s_pkt_q[A_W-1:0] == LOCAL_ADDR);

    assign bus.sw_rdy   = pe_rdy;
    assign bus.e_vld    = e_vld_q;
    assign bus.e_pkt    = e_pkt_q;
    assign bus.s_pkt    = s_pkt_q;
    assign bus.pe_vld   = s_raw_vld_q & local_hit;
    assign bus.s_vld    = s_raw_vld_q & ~local_hit;
    assign bus.defl_cnt = defl_cnt_q;
    assign bus.inj_cnt  = inj_cnt_q;

endmodule

// File: tb/tb_hoplite_sw.sv
// Self-checking bench for hoplite_sw at node (1,2) with 3-bit counters: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against a port-claiming model.
module tb_hoplite_sw;

    localparam int P_W     = 16;
    localparam int X_AW    = 2;
    localparam int Y_AW    = 2;
    localparam int X_POS   = 1;
    localparam int Y_POS   = 2;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    hoplite_sw_if #(.P_W(P_W), .CNT_W(CNT_W)) bus ();

    hoplite_sw #(
        .P_W(P_W), .X_AW(X_AW), .Y_AW(Y_AW),
        .X_POS(X_POS), .Y_POS(Y_POS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           e_v;
        logic [P_W-1:0] e_p;
        logic           s_v;
        logic [P_W-1:0] s_p;
        logic           rdy;
        logic           defl;
        logic           inj;
    } route_t;

    // Sources claim ports in priority order; a claimed port is simply unavailable to later sources.
    function automatic route_t arbitrate(input logic nv, input logic [P_W-1:0] np,
                                         input logic wv, input logic [P_W-1:0] wp,
                                         input logic pv, input logic [P_W-1:0] pp);
        route_t r;
        bit     pe_goes_south;
        r = '0;
        if (nv) begin
            r.s_v = 1'b1;
            r.s_p = np;
        end
        if (wv) begin
            if (int'(wp[1:0]) == X_POS && !r.s_v) begin
                r.s_v = 1'b1;
                r.s_p = wp;
            end else begin
                r.defl = (int'(wp[1:0]) == X_POS);
                r.e_v  = 1'b1;
                r.e_p  = wp;
            end
        end
        pe_goes_south = (int'(pp[1:0]) == X_POS);
        r.rdy = pe_goes_south ? !r.s_v : !r.e_v;
        if (pv && r.rdy) begin
            r.inj = 1'b1;
            if (pe_goes_south) begin
                r.s_v = 1'b1;
                r.s_p = pp;
            end else begin
                r.e_v = 1'b1;
                r.e_p = pp;
            end
        end
        return r;
    endfunction

    function automatic logic [P_W-1:0] mk_pkt(input int x, input int y, input int payload);
        return P_W'((payload << 4) | (y << 2) | x);
    endfunction

    logic           m_e_vld = 1'b0;
    logic [P_W-1:0] m_e_pkt = '0;
    logic           m_s_raw = 1'b0;
    logic [P_W-1:0] m_s_pkt = '0;
    int             m_defl  = 0;
    int             m_inj   = 0;

    always @(posedge clk or negedge rst) begin
        route_t r;
        if (!rst) begin
            m_e_vld = 1'b0;
            m_e_pkt = '0;
            m_s_raw = 1'b0;
            m_s_pkt = '0;
            m_defl  = 0;
            m_inj   = 0;
        end else begin
            r = arbitrate(bus.n_vld, bus.n_pkt, bus.w_vld, bus.w_pkt, bus.pe_in_vld, bus.pe_in_pkt);
            m_e_vld = r.e_v;
            if (r.e_v) m_e_pkt = r.e_p;
            m_s_raw = r.s_v;
            if (r.s_v) m_s_pkt = r.s_p;
            if (r.defl && m_defl < CNT_MAX) m_defl++;
            if (r.inj && m_inj < CNT_MAX) m_inj++;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs and the combinational ready are compared against the model every cycle.
    always @(negedge clk) begin
        route_t r;
        bit     m_local;
        r       = arbitrate(bus.n_vld, bus.n_pkt, bus.w_vld, bus.w_pkt, bus.pe_in_vld, bus.pe_in_pkt);
        m_local = m_s_raw && (int'(m_s_pkt[3:2]) == Y_POS) && (int'(m_s_pkt[1:0]) == X_POS);
        check_output("model e_vld",    32'(bus.e_vld),    32'(m_e_vld));
        check_output("model e_pkt",    32'(bus.e_pkt),    32'(m_e_pkt));
        check_output("model s_pkt",    32'(bus.s_pkt),    32'(m_s_pkt));
        check_output("model s_vld",    32'(bus.s_vld),    32'(m_s_raw && !m_local));
        check_output("model pe_vld",   32'(bus.pe_vld),   32'(m_local));
        check_output("model defl_cnt", 32'(bus.defl_cnt), 32'(m_defl));
        check_output("model inj_cnt",  32'(bus.inj_cnt),  32'(m_inj));
        if (rst) check_output("model sw_rdy", 32'(bus.sw_rdy), 32'(r.rdy));
    end

    task automatic apply_stimulus(input logic nv, input logic [P_W-1:0] np,
                                  input logic wv, input logic [P_W-1:0] wp,
                                  input logic pv, input logic [P_W-1:0] pp);
        @(negedge clk);
        #2;
        bus.n_vld     = nv;
        bus.n_pkt     = np;
        bus.w_vld     = wv;
        bus.w_pkt     = wp;
        bus.pe_in_vld = pv;
        bus.pe_in_pkt = pp;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " e_vld"},    32'(bus.e_vld),    32'h0);
        check_output({tag, " s_vld"},    32'(bus.s_vld),    32'h0);
        check_output({tag, " pe_vld"},   32'(bus.pe_vld),   32'h0);
        check_output({tag, " e_pkt"},    32'(bus.e_pkt),    32'h0);
        check_output({tag, " s_pkt"},    32'(bus.s_pkt),    32'h0);
        check_output({tag, " defl_cnt"}, 32'(bus.defl_cnt), 32'h0);
        check_output({tag, " inj_cnt"},  32'(bus.inj_cnt),  32'h0);
    endtask

    initial begin
        logic [P_W-1:0] pe_pkt;
        logic           pe_pend;
        route_t         r;

        bus.n_vld = 1'b0; bus.n_pkt = '0;
        bus.w_vld = 1'b0; bus.w_pkt = '0;
        bus.pe_in_vld = 1'b0; bus.pe_in_pkt = '0;

        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Mid-stream asynchronous reset with valids high
        apply_stimulus(1'b1, 16'h0551, 1'b1, 16'h0661, 1'b0, '0);
        after_edge();
        check_output("stream defl_cnt", 32'(bus.defl_cnt), 32'h1);
        check_output("stream e_vld",    32'(bus.e_vld),    32'h1);
        #1 rst = 1'b0;
        #1 check_all_zero("reset async");
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        after_edge();
        check_all_zero("reset release");

        // Pass-through on both axes
        apply_stimulus(1'b0, '0, 1'b1, 16'h0AB3, 1'b0, '0);
        after_edge();
        check_output("pass e_vld", 32'(bus.e_vld), 32'h1);
        check_output("pass e_pkt", 32'(bus.e_pkt), 32'h0AB3);
        check_output("pass s_vld", 32'(bus.s_vld), 32'h0);
        apply_stimulus(1'b1, 16'h0CD1, 1'b0, '0, 1'b0, '0);
        after_edge();
        check_output("pass n s_vld", 32'(bus.s_vld), 32'h1);
        check_output("pass n s_pkt", 32'(bus.s_pkt), 32'h0CD1);

        // Deflection of W by N
        apply_stimulus(1'b1, 16'h012D, 1'b1, 16'h0341, 1'b0, '0);
        after_edge();
        check_output("defl s_pkt",    32'(bus.s_pkt),    32'h012D);
        check_output("defl s_vld",    32'(bus.s_vld),    32'h1);
        check_output("defl e_pkt",    32'(bus.e_pkt),    32'h0341);
        check_output("defl e_vld",    32'(bus.e_vld),    32'h1);
        check_output("defl defl_cnt", 32'(bus.defl_cnt), 32'h1);

        // Injection blocked by W, then accepted
        apply_stimulus(1'b0, '0, 1'b1, 16'h0780, 1'b1, 16'h0562);
        #1 check_output("inj blocked sw_rdy", 32'(bus.sw_rdy), 32'h0);
        after_edge();
        check_output("inj blocked e_pkt",   32'(bus.e_pkt),   32'h0780);
        check_output("inj blocked inj_cnt", 32'(bus.inj_cnt), 32'h0);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 16'h0562);
        #1 check_output("inj free sw_rdy", 32'(bus.sw_rdy), 32'h1);
        after_edge();
        check_output("inj e_vld",   32'(bus.e_vld),   32'h1);
        check_output("inj e_pkt",   32'(bus.e_pkt),   32'h0562);
        check_output("inj inj_cnt", 32'(bus.inj_cnt), 32'h1);

        // Local delivery from N and from a self-addressed injection
        apply_stimulus(1'b1, 16'h09A9, 1'b0, '0, 1'b0, '0);
        after_edge();
        check_output("local pe_vld", 32'(bus.pe_vld), 32'h1);
        check_output("local s_vld",  32'(bus.s_vld),  32'h0);
        check_output("local s_pkt",  32'(bus.s_pkt),  32'h09A9);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 16'h0BC9);
        #1 check_output("self sw_rdy", 32'(bus.sw_rdy), 32'h1);
        after_edge();
        check_output("self pe_vld",  32'(bus.pe_vld),  32'h1);
        check_output("self s_pkt",   32'(bus.s_pkt),   32'h0BC9);
        check_output("self inj_cnt", 32'(bus.inj_cnt), 32'h2);

        // Nine more deflections saturate the 3-bit counter
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, mk_pkt(1, 0, i), 1'b1, mk_pkt(1, 0, 16 + i), 1'b0, '0);
        end
        after_edge();
        check_output("sat defl_cnt", 32'(bus.defl_cnt), 32'h7);
        apply_stimulus(1'b1, 16'h0111, 1'b1, 16'h0221, 1'b0, '0);
        after_edge();
        check_output("sat hold defl_cnt", 32'(bus.defl_cnt), 32'h7);

        // Randomized traffic; the PE holds its packet until the switch accepts it
        pe_pend = 1'b0;
        pe_pkt  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [P_W-1:0] np, wp;
            if (pe_pend) begin
                r = arbitrate(bus.n_vld, bus.n_pkt, bus.w_vld, bus.w_pkt, bus.pe_in_vld, bus.pe_in_pkt);
                if (r.inj) pe_pend = 1'b0;
            end
            if (!pe_pend && ($urandom_range(0, 9) < 5)) begin
                pe_pend = 1'b1;
                pe_pkt  = mk_pkt(($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 3)),
                                 int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            end
            np = mk_pkt(($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            wp = mk_pkt(($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            apply_stimulus($urandom_range(0, 9) < 6, np, $urandom_range(0, 9) < 6, wp, pe_pend, pe_pkt);
            if (cyc % 400 == 399) begin
                #1 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
                pe_pend = 1'b0;
                bus.pe_in_vld = 1'b0;
            end
        end

        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        after_edge();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
